// File: rtl/scheduler_bitinfo_parser.sv
// ---------------------------------------------------------------------------
// scheduler_bitinfo_parser
//
// Walks the xtasks.config table stored in bitinfo memory and writes one
// scheduling-data row per accelerator type: {task type, count-1, first acc id}.
// Each entry holds an ASCII-decimal task type, a tab, and an ASCII-decimal
// instance count. The walk ends on an all-ones word at an entry start (done)
// or on the first format/capacity violation (error).
//
// Ports
//   ap_clk, ap_rst_n        clock, synchronous active-low reset
//   start                   pulse: (re)parse from IDLE/DONE/ERROR
//   bitinfo_addr/en/dout    word read port (byte address, 1-cycle latency)
//   scheduleData_*          row write port (address, strobe, data)
//   busy, done, error       parse status (done/error sticky until restart)
//   error_code              1 digit, 2 separator, 3 zero count,
//                           4 acc overflow, 5 type overflow
//   num_acc_types           rows written
//   total_accs              sum of instance counts written
// ---------------------------------------------------------------------------
module scheduler_bitinfo_parser #(
  parameter int unsigned MAX_ACCS      = 16,
  parameter int unsigned MAX_ACC_TYPES = 16,
  parameter int unsigned TYPE_DIGITS   = 19,
  parameter int unsigned TYPE_BITS     = 34,
  parameter int unsigned INST_DIGITS   = 3,
  parameter int unsigned CFG_WORD_OFS  = 9,
  parameter int unsigned ENTRY_SKIP    = 9,
  parameter bit          AUTO_START    = 1'b1,
  localparam int unsigned ACC_BITS       = $clog2(MAX_ACCS),
  localparam int unsigned TYPE_ADDR_BITS = $clog2(MAX_ACC_TYPES)
) (
  input  logic                              ap_clk,
  input  logic                              ap_rst_n,
  input  logic                              start,
  output logic [31:0]                       bitinfo_addr,
  output logic                              bitinfo_en,
  input  logic [31:0]                       bitinfo_dout,
  output logic [TYPE_ADDR_BITS-1:0]         scheduleData_address0,
  output logic                              scheduleData_ce0,
  output logic [TYPE_BITS+2*ACC_BITS-1:0]   scheduleData_d0,
  output logic                              busy,
  output logic                              done,
  output logic                              error,
  output logic [2:0]                        error_code,
  output logic [TYPE_ADDR_BITS:0]           num_acc_types,
  output logic [ACC_BITS:0]                 total_accs
);

  // Byte positions inside one entry: type digits, separator, count digits.
  localparam int unsigned SEP_POS  = TYPE_DIGITS;
  localparam int unsigned LAST_POS = TYPE_DIGITS + INST_DIGITS;
  localparam int unsigned POS_BITS = $clog2(LAST_POS + 1);

  localparam logic [ACC_BITS+1:0]       MAX_ACCS_W  = (ACC_BITS+2)'(MAX_ACCS);
  localparam logic [TYPE_ADDR_BITS:0]   MAX_TYPES_W = (TYPE_ADDR_BITS+1)'(MAX_ACC_TYPES);
  localparam logic [29:0]               CFG_OFS_W   = 30'(CFG_WORD_OFS);
  localparam logic [29:0]               NEXT_ENTRY  = 30'(ENTRY_SKIP + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_FETCH, S_WAIT, S_PARSE, S_WRITE, S_DONE, S_ERROR
  } state_e;

  state_e                    state_q;
  logic [29:0]               word_idx_q;
  logic [POS_BITS-1:0]       pos_q;
  logic [31:0]               word_q;
  logic [TYPE_BITS-1:0]      type_q;
  logic [ACC_BITS:0]         cnt_q;
  logic [TYPE_ADDR_BITS:0]   row_q;
  logic [ACC_BITS:0]         total_q;
  logic [31:0]               addr_q;
  logic                      en_q;
  logic [TYPE_ADDR_BITS-1:0] waddr_q;
  logic                      ce_q;
  logic [TYPE_BITS+2*ACC_BITS-1:0] d0_q;
  logic                      busy_q, done_q, error_q;
  logic [2:0]                code_q;

  // Per-byte decode of the PARSE state.
  logic [7:0]                cur_byte;
  logic                      digit_ok;
  logic [TYPE_BITS-1:0]      type_d;
  logic [ACC_BITS:0]         cnt_d;
  logic [ACC_BITS+1:0]       sum_w;
  logic [ACC_BITS-1:0]       cnt_m1;
  logic [2:0]                p_code;
  logic                      p_write;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and a latch cannot be inferred.
    p_code   = 3'd0;
    p_write  = 1'b0;
    cur_byte = word_q[{pos_q[1:0], 3'b000} +: 8];
    digit_ok = (cur_byte[7:4] == 4'h3) && (cur_byte[3:0] <= 4'd9);
    // acc*10 + d as two shifts and two adds, truncated to the field width.
    type_d   = (type_q << 3) + (type_q << 1) + TYPE_BITS'(cur_byte[3:0]);
    cnt_d    = (cnt_q << 3) + (cnt_q << 1) + (ACC_BITS+1)'(cur_byte[3:0]);
    sum_w    = (ACC_BITS+2)'(total_q) + (ACC_BITS+2)'(cnt_d);
    cnt_m1   = cnt_d[ACC_BITS-1:0] - ACC_BITS'(1);

    if (pos_q < POS_BITS'(SEP_POS)) begin
      if (!digit_ok) p_code = 3'd1;
    end else if (pos_q == POS_BITS'(SEP_POS)) begin
      if (cur_byte != 8'h09) p_code = 3'd2;
    end else if (!digit_ok) begin
      p_code = 3'd1;
    end else if (pos_q == POS_BITS'(LAST_POS)) begin
      // Row checks happen before the write so a faulty row is never stored.
      if (cnt_d == '0)               p_code = 3'd3;
      else if (sum_w > MAX_ACCS_W)   p_code = 3'd4;
      else                           p_write = 1'b1;
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q    <= AUTO_START ? S_START : S_IDLE;
      word_idx_q <= CFG_OFS_W;
      pos_q      <= '0;
      word_q     <= '0;
      type_q     <= '0;
      cnt_q      <= '0;
      row_q      <= '0;
      total_q    <= '0;
      addr_q     <= '0;
      en_q       <= 1'b0;
      waddr_q    <= '0;
      ce_q       <= 1'b0;
      d0_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      code_q     <= '0;
    end else begin
      // NOTE: strobes default low here and are raised only on the transition
      // into FETCH/WRITE, so each is a single-cycle registered pulse.
      en_q <= 1'b0;
      ce_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) state_q <= S_START;

        S_START: begin
          busy_q     <= 1'b1;
          done_q     <= 1'b0;
          error_q    <= 1'b0;
          code_q     <= '0;
          row_q      <= '0;
          total_q    <= '0;
          type_q     <= '0;
          cnt_q      <= '0;
          pos_q      <= '0;
          word_idx_q <= CFG_OFS_W;
          addr_q     <= {CFG_OFS_W, 2'b00};
          en_q       <= 1'b1;
          state_q    <= S_FETCH;
        end

        S_FETCH: state_q <= S_WAIT;

        S_WAIT: begin
          word_q <= bitinfo_dout;
          if (pos_q == '0 && bitinfo_dout == 32'hFFFF_FFFF) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else if (pos_q == '0 && row_q == MAX_TYPES_W) begin
            error_q <= 1'b1;
            code_q  <= 3'd5;
            busy_q  <= 1'b0;
            state_q <= S_ERROR;
          end else begin
            state_q <= S_PARSE;
          end
        end

        S_PARSE: begin
          if (p_code != 3'd0) begin
            error_q <= 1'b1;
            code_q  <= p_code;
            busy_q  <= 1'b0;
            state_q <= S_ERROR;
          end else begin
            if (pos_q < POS_BITS'(SEP_POS)) type_q <= type_d;
            if (pos_q > POS_BITS'(SEP_POS)) cnt_q  <= cnt_d;
            if (p_write) begin
              ce_q    <= 1'b1;
              waddr_q <= row_q[TYPE_ADDR_BITS-1:0];
              d0_q    <= {type_q, cnt_m1, total_q[ACC_BITS-1:0]};
              state_q <= S_WRITE;
            end else begin
              pos_q <= pos_q + POS_BITS'(1);
              // Entries are word aligned, so byte lane 3 ends the word.
              if (pos_q[1:0] == 2'b11) begin
                word_idx_q <= word_idx_q + 30'd1;
                addr_q     <= {word_idx_q + 30'd1, 2'b00};
                en_q       <= 1'b1;
                state_q    <= S_FETCH;
              end
            end
          end
        end

        S_WRITE: begin
          // First id of the next row equals the running total.
          total_q    <= total_q + cnt_q;
          row_q      <= row_q + 1'b1;
          word_idx_q <= word_idx_q + NEXT_ENTRY;
          addr_q     <= {word_idx_q + NEXT_ENTRY, 2'b00};
          en_q       <= 1'b1;
          pos_q      <= '0;
          type_q     <= '0;
          cnt_q      <= '0;
          state_q    <= S_FETCH;
        end

        S_DONE, S_ERROR: if (start) state_q <= S_START;

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bitinfo_addr          = addr_q;
  assign bitinfo_en            = en_q;
  assign scheduleData_address0 = waddr_q;
  assign scheduleData_ce0      = ce_q;
  assign scheduleData_d0       = d0_q;
  assign busy                  = busy_q;
  assign done                  = done_q;
  assign error                 = error_q;
  assign error_code            = code_q;
  assign num_acc_types         = row_q;
  assign total_accs            = total_q;

endmodule

// File: tb/tb_scheduler_bitinfo_parser.sv
// ---------------------------------------------------------------------------
// tb_scheduler_bitinfo_parser
//
// Builds xtasks.config images in a behavioural bitinfo memory, lets the
// parser walk them and compares status and written rows against expected
// values derived from the table layout rules (directed table, a reset
// sequence, and random configurations).
// ---------------------------------------------------------------------------
module tb_scheduler_bitinfo_parser;

  localparam int MAXE = 20;
  localparam int MEMW = 1024;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] bitinfo_addr;
  logic        bitinfo_en;
  logic [31:0] bitinfo_dout = 32'h0;
  logic [3:0]  sd_addr;
  logic        sd_ce;
  logic [41:0] sd_d;
  logic        busy, done, error;
  logic [2:0]  error_code;
  logic [4:0]  num_acc_types;
  logic [4:0]  total_accs;

  always #5 ap_clk = ~ap_clk;

  scheduler_bitinfo_parser dut (
    .ap_clk                (ap_clk),
    .ap_rst_n              (ap_rst_n),
    .start                 (start),
    .bitinfo_addr          (bitinfo_addr),
    .bitinfo_en            (bitinfo_en),
    .bitinfo_dout          (bitinfo_dout),
    .scheduleData_address0 (sd_addr),
    .scheduleData_ce0      (sd_ce),
    .scheduleData_d0       (sd_d),
    .busy                  (busy),
    .done                  (done),
    .error                 (error),
    .error_code            (error_code),
    .num_acc_types         (num_acc_types),
    .total_accs            (total_accs)
  );

  // Bitinfo memory: one-cycle read latency.
  logic [31:0] mem [MEMW];
  always @(posedge ap_clk)
    if (bitinfo_en) bitinfo_dout <= mem[bitinfo_addr[11:2]];

  // Row-write monitor.
  logic [3:0]  cap_a [$];
  logic [41:0] cap_d [$];
  always @(negedge ap_clk)
    if (sd_ce) begin
      cap_a.push_back(sd_addr);
      cap_d.push_back(sd_d);
    end

  // Configuration under test.
  int              ent_n;
  longint unsigned ent_type [MAXE];
  int              ent_cnt  [MAXE];
  int              bad_kind;   // 0 none, 1 type digit, 2 separator, 3 count digit
  int              bad_entry;

  // Reference results.
  bit          m_done;
  int          m_code, m_rows, m_accs;
  logic [41:0] m_d [MAXE];

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic put_byte(input int ba, input logic [7:0] b);
    mem[ba / 4][8 * (ba % 4) +: 8] = b;
  endtask

  function automatic int entry_base(input int i);
    return (9 + 15 * i) * 4;
  endfunction

  task automatic build_mem();
    longint unsigned v;
    int c;
    for (int w = 0; w < MEMW; w++) mem[w] = 32'h4142_4344;
    for (int i = 0; i < ent_n; i++) begin
      v = ent_type[i];
      for (int j = 18; j >= 0; j--) begin
        put_byte(entry_base(i) + j, 8'h30 + 8'(v % 10));
        v = v / 10;
      end
      put_byte(entry_base(i) + 19, 8'h09);
      c = ent_cnt[i];
      for (int j = 22; j >= 20; j--) begin
        put_byte(entry_base(i) + j, 8'h30 + 8'(c % 10));
        c = c / 10;
      end
      put_byte(entry_base(i) + 23, 8'h09);
    end
    case (bad_kind)
      1: put_byte(entry_base(bad_entry) + 8,  8'h41);
      2: put_byte(entry_base(bad_entry) + 19, 8'h20);
      3: put_byte(entry_base(bad_entry) + 21, 8'h3A);
      default: ;
    endcase
    mem[9 + 15 * ent_n] = 32'hFFFF_FFFF;
  endtask

  // Entry-by-entry walk of the configuration using the table rules.
  task automatic model();
    int total, c;
    logic [3:0] cm1;
    m_done = 1'b0; m_code = 0; m_rows = 0; total = 0;
    for (int i = 0; i <= ent_n; i++) begin
      if (i == ent_n) begin m_done = 1'b1; break; end
      if (i == 16) begin m_code = 5; break; end
      if (bad_kind != 0 && bad_entry == i) begin
        m_code = (bad_kind == 2) ? 2 : 1;
        break;
      end
      c = ent_cnt[i] % 32;
      if (c == 0) begin m_code = 3; break; end
      if (total + c > 16) begin m_code = 4; break; end
      cm1 = 4'(c - 1);
      m_d[m_rows] = {ent_type[i][33:0], cm1, 4'(total)};
      m_rows++;
      total += c;
    end
    m_accs = total;
  endtask

  task automatic wait_run(input string nm);
    bit seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge ap_clk);
      if (busy) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      n_vec++; n_bad++;
      $display("FAIL %s: busy never rose", nm);
      return;
    end
    for (int k = 0; k < 4000; k++) begin
      @(negedge ap_clk);
      if (done || error) return;
    end
    n_vec++; n_bad++;
    $display("FAIL %s: parse did not finish within cycle budget", nm);
  endtask

  task automatic check_results(input string nm, input bit x_done, input int x_code,
                               input int x_rows, input int x_accs);
    check({nm, ".busy"},  64'(busy), 64'(0));
    check({nm, ".done"},  64'(done), 64'(x_done));
    check({nm, ".error"}, 64'(error), 64'(!x_done));
    check({nm, ".code"},  64'(error_code), 64'(x_code));
    check({nm, ".rows"},  64'(num_acc_types), 64'(x_rows));
    check({nm, ".accs"},  64'(total_accs), 64'(x_accs));
    check({nm, ".writes"}, 64'(cap_a.size()), 64'(x_rows));
    for (int i = 0; i < x_rows && i < cap_a.size(); i++) begin
      check($sformatf("%s.addr%0d", nm, i), 64'(cap_a[i]), 64'(i));
      check($sformatf("%s.d0_%0d", nm, i), 64'(cap_d[i]), 64'(m_d[i]));
    end
  endtask

  task automatic pulse_start();
    @(negedge ap_clk); start = 1'b1;
    @(negedge ap_clk); start = 1'b0;
  endtask

  task automatic setup_from(input int n, input int c0, input int c1, input int c2,
                            input int bk, input int be);
    ent_n = n; bad_kind = bk; bad_entry = be;
    for (int i = 0; i < MAXE; i++) begin
      ent_type[i] = 64'd123 + 64'(i) * 64'd98765432109;
      ent_cnt[i]  = (i == 0) ? c0 : (i == 1) ? c1 : (i == 2) ? c2 : 1;
    end
  endtask

  typedef struct {
    int n; int c0; int c1; int c2;
    int bad_kind; int bad_entry;
    bit x_done; int x_code; int x_rows; int x_accs;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{1,  2,  0, 0, 0, 0, 1'b1, 0, 1,  2};
    tbl[1]  = '{3,  3,  1, 4, 0, 0, 1'b1, 0, 3,  8};
    tbl[2]  = '{2,  10, 7, 0, 0, 0, 1'b0, 4, 1,  10};
    tbl[3]  = '{2,  1,  0, 0, 0, 0, 1'b0, 3, 1,  1};
    tbl[4]  = '{2,  1,  2, 0, 1, 0, 1'b0, 1, 0,  0};
    tbl[5]  = '{2,  1,  2, 0, 2, 0, 1'b0, 2, 0,  0};
    tbl[6]  = '{3,  2,  3, 1, 3, 1, 1'b0, 1, 1,  2};
    tbl[7]  = '{17, 1,  1, 1, 0, 0, 1'b0, 5, 16, 16};
    tbl[8]  = '{16, 1,  1, 1, 0, 0, 1'b1, 0, 16, 16};
    tbl[9]  = '{0,  0,  0, 0, 0, 0, 1'b1, 0, 0,  0};
    tbl[10] = '{1,  16, 0, 0, 0, 0, 1'b1, 0, 1,  16};
    tbl[11] = '{1,  17, 0, 0, 0, 0, 1'b0, 4, 0,  0};

    // Reset state.
    setup_from(tbl[0].n, tbl[0].c0, tbl[0].c1, tbl[0].c2, tbl[0].bad_kind, tbl[0].bad_entry);
    build_mem();
    repeat (3) @(negedge ap_clk);
    check("rst.busy",  64'(busy), 64'(0));
    check("rst.done",  64'(done), 64'(0));
    check("rst.error", 64'(error), 64'(0));
    check("rst.code",  64'(error_code), 64'(0));
    check("rst.en",    64'(bitinfo_en), 64'(0));
    check("rst.addr",  64'(bitinfo_addr), 64'(0));
    check("rst.ce0",   64'(sd_ce), 64'(0));
    check("rst.rows",  64'(num_acc_types), 64'(0));
    check("rst.accs",  64'(total_accs), 64'(0));

    // Directed table: first vector auto-starts out of reset, the rest restart
    // from DONE/ERROR with a fresh memory image.
    for (int v = 0; v < 12; v++) begin
      setup_from(tbl[v].n, tbl[v].c0, tbl[v].c1, tbl[v].c2, tbl[v].bad_kind, tbl[v].bad_entry);
      build_mem();
      model();
      cap_a.delete(); cap_d.delete();
      if (v == 0) begin
        @(negedge ap_clk); ap_rst_n = 1'b1;
      end else begin
        pulse_start();
      end
      wait_run($sformatf("vec%0d", v));
      check_results($sformatf("vec%0d", v), tbl[v].x_done, tbl[v].x_code,
                    tbl[v].x_rows, tbl[v].x_accs);
    end

    // Reset in the middle of a parse, then auto-start re-parse; a start pulse
    // while busy must be ignored.
    setup_from(3, 3, 1, 4, 0, 0);
    build_mem();
    model();
    pulse_start();
    repeat (30) @(negedge ap_clk);
    ap_rst_n = 1'b0;
    repeat (2) @(negedge ap_clk);
    check("midrst.busy", 64'(busy), 64'(0));
    check("midrst.ce0",  64'(sd_ce), 64'(0));
    check("midrst.rows", 64'(num_acc_types), 64'(0));
    cap_a.delete(); cap_d.delete();
    ap_rst_n = 1'b1;
    repeat (20) @(negedge ap_clk);
    start = 1'b1;
    @(negedge ap_clk); start = 1'b0;
    wait_run("midrst");
    check_results("midrst", m_done, m_code, m_rows, m_accs);

    // Random configurations against the reference walk.
    for (int r = 0; r < 10; r++) begin
      ent_n = $urandom_range(1, 4);
      bad_kind = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      bad_entry = $urandom_range(0, ent_n - 1);
      for (int i = 0; i < MAXE; i++) begin
        ent_type[i] = {$urandom, $urandom} % 64'd10000000000000000000;
        ent_cnt[i]  = $urandom_range(0, 6);
      end
      build_mem();
      model();
      cap_a.delete(); cap_d.delete();
      pulse_start();
      wait_run($sformatf("rnd%0d", r));
      check_results($sformatf("rnd%0d", r), m_done, m_code, m_rows, m_accs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
